// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the i2c command sequencer slice:
//   - FSM state encoding
//   - default memory-address width and per-phase timeout
//   - cmd_w(): packed command width (rw + 7-bit addr + mem addr + wdata)
// ---------------------------------------------------------------------------
package i2c_pkg;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LAUNCH    = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_RESP      = 3'd4;

   localparam int DEF_AW      = 5;
   localparam int DEF_TIMEOUT = 4095;

   // CMD_W = 1 + 7 + AW + 8
   function automatic int cmd_w(input int aw);
      return 1 + 7 + aw + 8;
   endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// ---------------------------------------------------------------------------
// i2c_cmd_fifo
// Synchronous DEPTH x W command FIFO with occupancy output.
// Ports:
//   i_clk, i_rst (sync, active low)
//   i_push/i_din  : write side, ignored when full
//   i_pop/o_dout  : read side, o_dout shows the head entry, pop ignored when empty
//   o_full, o_empty, o_level (0..DEPTH)
// ---------------------------------------------------------------------------
module i2c_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 21
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_din,
   input  logic                     i_pop,
   output logic [W-1:0]             o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_level == LVL_FULL);
   assign o_empty = (r_level == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_dout  = r_mem[r_rptr];
   assign o_level = r_level;

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer
// Buffers register-access commands and runs them one at a time through the
// i2c_master en/busy handshake, returning one response per command.
// Optional feature macro: I2C_SEQ_RETRY_EN -- on ack error, relaunch the same
// command up to 2 more times; only the final attempt's error is reported.
// Ports:
//   i_clk, i_rst (sync, active low)
//   command in : i_cmd_valid/o_cmd_ready, i_cmd_rw, i_cmd_addr, i_cmd_mem_addr, i_cmd_wdata
//   response   : o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err, o_rsp_timeout
//   o_level    : FIFO occupancy
//   master     : o_m_en, o_m_rw, o_m_addr, o_m_mem_addr, o_m_data_wr,
//                i_m_data_rd, i_m_ack_err, i_m_busy
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer
   import i2c_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int AW      = DEF_AW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic                   i_cmd_rw,
   input  logic [6:0]             i_cmd_addr,
   input  logic [AW-1:0]          i_cmd_mem_addr,
   input  logic [7:0]             i_cmd_wdata,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [7:0]             o_rsp_rdata,
   output logic                   o_rsp_err,
   output logic                   o_rsp_timeout,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_m_en,
   output logic                   o_m_rw,
   output logic [6:0]             o_m_addr,
   output logic [AW-1:0]          o_m_mem_addr,
   output logic [7:0]             o_m_data_wr,
   input  logic [7:0]             i_m_data_rd,
   input  logic                   i_m_ack_err,
   input  logic                   i_m_busy
);

   localparam int CW = cmd_w(AW);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [TW-1:0] r_timer;
   logic          w_tout;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_head;
   logic          w_retry;

   logic          r_m_rw;
   logic [6:0]    r_m_addr;
   logic [AW-1:0] r_m_mem_addr;
   logic [7:0]    r_m_data_wr;
   logic [7:0]    r_rsp_rdata;
   logic          r_rsp_err;
   logic          r_rsp_timeout;

   assign w_push = i_cmd_valid & ~w_full;
   // Only pop when the master is idle, so a launch never lands on a busy master.
   assign w_pop  = (r_state == S_IDLE) & ~w_empty & ~i_m_busy;
   assign w_tout = (r_timer == TMAX);

   i2c_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_din   ({i_cmd_rw, i_cmd_addr, i_cmd_mem_addr, i_cmd_wdata}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

`ifdef I2C_SEQ_RETRY_EN
   logic [1:0] r_retry;
   assign w_retry = i_m_ack_err & (r_retry != 2'd2);
`else
   assign w_retry = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_pop) w_next = S_LAUNCH;
         // Hold the pulse off if someone else grabbed the master meanwhile.
         S_LAUNCH:    if (!i_m_busy) w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: if (i_m_busy) w_next = S_WAIT_DONE;
                      else if (w_tout) w_next = S_RESP;
         S_WAIT_DONE: if (!i_m_busy) w_next = w_retry ? S_LAUNCH : S_RESP;
                      else if (w_tout) w_next = S_RESP;
         S_RESP:      if (i_rsp_ready) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_m_rw        <= 1'b0;
         r_m_addr      <= '0;
         r_m_mem_addr  <= '0;
         r_m_data_wr   <= '0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
         r_retry       <= '0;
`endif
      end else begin
         r_state <= w_next;
         // Timer restarts on every state change, including a retry relaunch.
         r_timer <= (w_next != r_state) ? '0 : r_timer + 1'b1;
         case (r_state)
            S_IDLE: if (w_pop) begin
               {r_m_rw, r_m_addr, r_m_mem_addr, r_m_data_wr} <= w_head;
               r_rsp_rdata   <= '0;
               r_rsp_err     <= 1'b0;
               r_rsp_timeout <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
               r_retry       <= '0;
`endif
            end
            S_WAIT_BUSY: if (!i_m_busy && w_tout) r_rsp_timeout <= 1'b1;
            S_WAIT_DONE: if (!i_m_busy) begin
               r_rsp_rdata <= r_m_rw ? 8'h00 : i_m_data_rd;
               r_rsp_err   <= i_m_ack_err;
`ifdef I2C_SEQ_RETRY_EN
               if (w_retry) r_retry <= r_retry + 2'd1;
`endif
            end else if (w_tout) begin
               r_rsp_timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_cmd_ready   = ~w_full;
   assign o_m_en        = (r_state == S_LAUNCH) & ~i_m_busy;
   assign o_m_rw        = r_m_rw;
   assign o_m_addr      = r_m_addr;
   assign o_m_mem_addr  = r_m_mem_addr;
   assign o_m_data_wr   = r_m_data_wr;
   assign o_rsp_valid   = (r_state == S_RESP);
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_rsp_err     = r_rsp_err;
   assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
// Bench for i2c_cmd_sequencer: a behavioural i2c_master/slave model, a
// scoreboard of accepted commands with their expected responses, a per-cycle
// compare process, and directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int TO    = 20;
`ifdef I2C_SEQ_RETRY_EN
   localparam int NACK_LAUNCHES = 3;
`else
   localparam int NACK_LAUNCHES = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rw = 1'b0;
   logic [6:0]    cmd_addr = '0;
   logic [AW-1:0] cmd_mem_addr = '0;
   logic [7:0]    cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [7:0]    rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic [$clog2(DEPTH):0] level;
   logic          m_en;
   logic          m_rw;
   logic [6:0]    m_addr;
   logic [AW-1:0] m_mem_addr;
   logic [7:0]    m_data_wr;
   logic [7:0]    m_data_rd = '0;
   logic          m_ack_err = 1'b0;
   logic          m_busy;

   always #5 clk = ~clk;

   i2c_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
      .i_cmd_addr(cmd_addr), .i_cmd_mem_addr(cmd_mem_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout), .o_level(level),
      .o_m_en(m_en), .o_m_rw(m_rw), .o_m_addr(m_addr), .o_m_mem_addr(m_mem_addr),
      .o_m_data_wr(m_data_wr), .i_m_data_rd(m_data_rd), .i_m_ack_err(m_ack_err),
      .i_m_busy(m_busy)
   );

   typedef struct {
      logic          rw;
      logic [6:0]    addr;
      logic [AW-1:0] mem;
      logic [7:0]    wd;
      bit            to;
      logic [7:0]    rdata;
      bit            err;
      int            launches;
   } exp_t;

   exp_t       q[$];
   logic [7:0] slave_mem  [2][32];
   logic [7:0] shadow_mem [2][32];
   int         checks = 0;
   int         errors = 0;
   bit         mon_on = 0;
   bit         exp_to_flag = 0;
   bit         master_stuck = 0;
   bit         force_busy = 0;
   logic       busy_r = 1'b0;
   int         rr_mode = 0;
   logic       rr_val = 1'b1;
   int         cyc = 0;
   int         men_total = 0;
   logic       men_rw = 1'b0;
   logic [6:0] men_addr = '0;

   assign m_busy = busy_r | force_busy;

   function automatic bit present(input logic [6:0] a);
      return (a == 7'd1) || (a == 7'd2);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // rsp_ready driver: either held at rr_val or randomized per cycle.
   initial forever begin
      @(posedge clk); #1;
      rsp_ready = (rr_mode == 1) ? 1'($urandom_range(0, 1)) : rr_val;
   end

   // i2c_master + slaves model: slaves at 1 and 2, everything else NACKs.
   initial begin
      logic          t_rw;
      logic [6:0]    t_a;
      logic [AW-1:0] t_m;
      logic [7:0]    t_d;
      int            d1, d2;
      forever begin
         @(negedge clk);
         if (rst && m_en && !master_stuck) begin
            t_rw = m_rw; t_a = m_addr; t_m = m_mem_addr; t_d = m_data_wr;
            d1 = $urandom_range(0, 2);
            d2 = $urandom_range(1, 4);
            @(posedge clk);
            repeat (d1) @(posedge clk);
            #1 busy_r = 1'b1;
            repeat (d2) @(posedge clk);
            #1;
            busy_r = 1'b0;
            if (present(t_a)) begin
               m_ack_err = 1'b0;
               if (t_rw) begin
                  slave_mem[t_a-1][t_m] = t_d;
                  m_data_rd = 8'($urandom);
               end else begin
                  m_data_rd = slave_mem[t_a-1][t_m];
               end
            end else begin
               m_ack_err = 1'b1;
               m_data_rd = 8'hFF;
            end
         end
      end
   end

   // Compare process: scoreboard and per-cycle properties.
   initial begin
      int         inflight, men_cnt, last_men;
      logic       prev_valid, prev_ready, prev_err, prev_to;
      logic [7:0] prev_rd;
      exp_t       e;
      inflight = 0; men_cnt = 0; last_men = 0;
      prev_valid = 0; prev_ready = 0; prev_err = 0; prev_to = 0; prev_rd = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mon_on || !rst) begin
            q.delete();
            inflight = 0; men_cnt = 0; prev_valid = 0;
            continue;
         end
         chk("men_while_busy", 32'(m_en & m_busy), 0);
         if (m_en) begin
            men_total++; men_cnt++; inflight = 1; last_men = cyc;
            men_rw = m_rw; men_addr = m_addr;
            chk("men_has_cmd", 32'(q.size() > 0), 1);
            if (q.size() > 0)
               chk("men_fields", {m_rw, m_addr, m_mem_addr, m_data_wr},
                   {q[0].rw, q[0].addr, q[0].mem, q[0].wd});
         end
         chk("level", 32'(level), 32'(q.size() - inflight));
         chk("cmd_ready", 32'(cmd_ready), 32'((q.size() - inflight) != DEPTH));
         if (rsp_valid) chk("rsp_has_cmd", 32'(q.size() > 0), 1);
         if (rsp_valid && !prev_valid && q.size() > 0 && q[0].to)
            chk("timeout_latency", 32'(cyc - last_men), TO + 2);
         if (prev_valid && !prev_ready) begin
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_fields", {rsp_rdata, rsp_err, rsp_timeout}, {prev_rd, prev_err, prev_to});
            chk("stall_no_men", 32'(m_en), 0);
         end
         if (rsp_valid && rsp_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            chk("launches", 32'(men_cnt), 32'(e.launches));
            inflight = 0; men_cnt = 0;
         end
         if (cmd_valid && cmd_ready) begin
            e.rw = cmd_rw; e.addr = cmd_addr; e.mem = cmd_mem_addr; e.wd = cmd_wdata;
            e.to = exp_to_flag; e.launches = 1; e.err = 0; e.rdata = 8'h00;
            if (!e.to) begin
               if (!present(e.addr)) begin
                  e.err = 1; e.launches = NACK_LAUNCHES;
                  e.rdata = e.rw ? 8'h00 : 8'hFF;
               end else if (e.rw) begin
                  shadow_mem[e.addr-1][e.mem] = e.wd;
               end else begin
                  e.rdata = shadow_mem[e.addr-1][e.mem];
               end
            end
            q.push_back(e);
         end
         prev_valid = rsp_valid; prev_ready = rsp_ready;
         prev_rd = rsp_rdata; prev_err = rsp_err; prev_to = rsp_timeout;
      end
   end

   task automatic push_cmd(input logic rw, input logic [6:0] a,
                           input logic [AW-1:0] m, input logic [7:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_mem_addr = m; cmd_wdata = d;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 2000);
      chk("push_wait", 32'(n < 2000), 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string nm, output logic [7:0] rd,
                           output logic er, output logic tmo);
      int n;
      n = 0; rd = '0; er = 0; tmo = 0;
      do begin @(negedge clk); n++; end while (!(rsp_valid && rsp_ready) && n < 1000);
      chk({nm, "_wait"}, 32'(n < 1000), 1);
      rd = rsp_rdata; er = rsp_err; tmo = rsp_timeout;
      @(posedge clk); #1;
   endtask

   task automatic wait_busy(input string nm);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!busy_r && n < 1000);
      chk({nm, "_busy_wait"}, 32'(n < 1000), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic       er, tmo;
      logic [7:0] exp_rd [5];
      int         men0, n, cnt;
      for (int a = 0; a < 2; a++)
         for (int m = 0; m < 32; m++) begin
            slave_mem[a][m] = 8'($urandom);
            shadow_mem[a][m] = slave_mem[a][m];
         end
      exp_rd[0] = 8'hAA; exp_rd[1] = 8'hBB; exp_rd[2] = 8'hCC; exp_rd[3] = 8'hDD; exp_rd[4] = 8'hBB;
      for (int m = 0; m < 4; m++) begin
         slave_mem[1][m] = exp_rd[m];
         shadow_mem[1][m] = exp_rd[m];
      end

      // 1. reset
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_en", 32'(m_en), 0);
      chk("rst_m_fields", {m_rw, m_addr, m_mem_addr, m_data_wr}, 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      @(posedge clk); #1;
      rst = 1'b1; mon_on = 1;

      // 2. single write
      men0 = men_total;
      push_cmd(1'b1, 7'd1, 5'd3, 8'h33);
      wait_rsp("wr", rd, er, tmo);
      chk("wr_rdata", 32'(rd), 32'h00);
      chk("wr_err", 32'(er), 0);
      chk("wr_men_count", 32'(men_total - men0), 1);
      chk("wr_m_addr", 32'(men_addr), 1);
      chk("wr_m_rw", 32'(men_rw), 1);

      // 3. fill FIFO while the master is held busy, then read back in order
      force_busy = 1;
      for (int m = 0; m < 4; m++) push_cmd(1'b0, 7'd2, AW'(m), 8'h00);
      @(negedge clk);
      chk("full_level", 32'(level), 4);
      chk("full_cmd_ready", 32'(cmd_ready), 0);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'd2; cmd_mem_addr = 5'd1; cmd_wdata = 8'h00;
      repeat (3) begin
         @(negedge clk);
         chk("full_push_ignored", 32'(level), 4);
      end
      force_busy = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
      chk("fifth_push_wait", 32'(n < 100), 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_rsp("rd", rd, er, tmo);
         chk("rd_order", 32'(rd), 32'(exp_rd[i]));
      end

      // 4. NACK
      men0 = men_total;
      push_cmd(1'b0, 7'd5, 5'd7, 8'h00);
      wait_rsp("nack", rd, er, tmo);
      chk("nack_err", 32'(er), 1);
      chk("nack_men_count", 32'(men_total - men0), NACK_LAUNCHES);

      // 5. stuck master: timeout, then the next queued command still runs
      rr_val = 1'b0; master_stuck = 1; exp_to_flag = 1;
      push_cmd(1'b0, 7'd2, 5'd2, 8'h00);
      exp_to_flag = 0;
      push_cmd(1'b0, 7'd2, 5'd3, 8'h00);
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 1000);
      chk("stuck_rsp_wait", 32'(n < 1000), 1);
      chk("stuck_timeout_flag", 32'(rsp_timeout), 1);
      master_stuck = 0; rr_val = 1'b1;
      wait_rsp("stuck", rd, er, tmo);
      chk("stuck_rsp_timeout", 32'(tmo), 1);
      wait_rsp("after_stuck", rd, er, tmo);
      chk("after_stuck_rdata", 32'(rd), 32'hDD);
      chk("after_stuck_timeout", 32'(tmo), 0);

      // random traffic
      rr_mode = 1;
      for (int i = 0; i < 60; i++) begin
         logic [6:0] a;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         case ($urandom_range(0, 3))
            0: a = 7'd1;
            1, 2: a = 7'd2;
            default: a = 7'd5;
         endcase
         push_cmd(1'($urandom_range(0, 1)), a, AW'($urandom_range(0, 31)), 8'($urandom));
      end
      n = 0;
      while (q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
      chk("random_drain", 32'(n < 5000), 1);
      rr_mode = 0; rr_val = 1'b1;

      // 6a. backpressure: held response, no new launch
      rr_val = 1'b0;
      repeat (2) @(posedge clk);
      push_cmd(1'b0, 7'd2, 5'd0, 8'h00);
      push_cmd(1'b1, 7'd1, 5'd5, 8'h5A);
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 1000);
      chk("bp_rsp_wait", 32'(n < 1000), 1);
      men0 = men_total;
      repeat (10) @(negedge clk);
      chk("bp_no_men", 32'(men_total - men0), 0);
      chk("bp_valid_held", 32'(rsp_valid), 1);
      chk("bp_level", 32'(level), 1);
      rr_val = 1'b1;
      wait_rsp("bp1", rd, er, tmo);
      wait_rsp("bp2", rd, er, tmo);
      chk("bp2_rdata", 32'(rd), 0);
      chk("bp2_err", 32'(er), 0);

      // 6b. reset in WAIT_DONE flushes the FIFO
      force_busy = 1;
      for (int i = 0; i < 3; i++) push_cmd(1'b0, 7'd2, AW'(i), 8'h00);
      force_busy = 0;
      wait_busy("mid_rst");
      @(negedge clk);
      mon_on = 0; rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_m_en", 32'(m_en), 0);
      chk("mid_rst_m_addr", 32'(m_addr), 0);
      rst = 1'b1;
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (m_en) cnt++;
      end
      chk("mid_rst_no_launch", 32'(cnt), 0);
      chk("mid_rst_level_after", 32'(level), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
